// File: rtl/demux_1x8_reg_n.sv
// Registered 1-to-8 distributor: stores DIN into one of eight slots,
// addressed directly by SEL or by an auto-incrementing write pointer.
module demux_1x8_reg_n #(
   parameter int BITS = 3
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic [BITS-1:0] DIN,
   input  logic [2:0]      SEL,
   input  logic            WE,
   input  logic            AUTO,
   input  logic            CLR,
   output logic [BITS-1:0] Q0,
   output logic [BITS-1:0] Q1,
   output logic [BITS-1:0] Q2,
   output logic [BITS-1:0] Q3,
   output logic [BITS-1:0] Q4,
   output logic [BITS-1:0] Q5,
   output logic [BITS-1:0] Q6,
   output logic [BITS-1:0] Q7,
   output logic [7:0]      VALID,
   output logic [2:0]      PTR,
   output logic            FULL,
   output logic            DONE
);

   logic [BITS-1:0] r_q     [8];
   logic [BITS-1:0] w_q_nxt [8];
   logic [7:0]      r_valid;
   logic [7:0]      w_valid_nxt;
   logic [2:0]      r_ptr;
   logic [2:0]      w_ptr_nxt;
   logic            r_full;
   logic            r_done;
   logic            w_full_nxt;

   always_comb begin
      w_q_nxt     = r_q;
      w_valid_nxt = r_valid;
      w_ptr_nxt   = r_ptr;
      if (CLR) begin
         w_q_nxt     = '{default: '0};
         w_valid_nxt = '0;
         w_ptr_nxt   = '0;
      end else if (WE) begin
         if (!AUTO) begin
            w_q_nxt[SEL]     = DIN;
            w_valid_nxt[SEL] = 1'b1;
         end else if (!r_full) begin
            w_q_nxt[r_ptr]     = DIN;
            w_valid_nxt[r_ptr] = 1'b1;
            w_ptr_nxt          = r_ptr + 3'd1;
         end
      end
      // FULL tracks the next-state VALID so it rises on the completing edge
      w_full_nxt = &w_valid_nxt;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_q     <= '{default: '0};
         r_valid <= '0;
         r_ptr   <= '0;
         r_full  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_q     <= w_q_nxt;
         r_valid <= w_valid_nxt;
         r_ptr   <= w_ptr_nxt;
         r_full  <= w_full_nxt;
         r_done  <= w_full_nxt & ~r_full;
      end
   end

   assign Q0    = r_q[0];
   assign Q1    = r_q[1];
   assign Q2    = r_q[2];
   assign Q3    = r_q[3];
   assign Q4    = r_q[4];
   assign Q5    = r_q[5];
   assign Q6    = r_q[6];
   assign Q7    = r_q[7];
   assign VALID = r_valid;
   assign PTR   = r_ptr;
   assign FULL  = r_full;
   assign DONE  = r_done;

endmodule

// File: tb/tb_demux_1x8_reg_n.sv
// Bench for demux_1x8_reg_n: directed test-plan steps then random traffic,
// each edge checked against a slot-array reference model.
module tb_demux_1x8_reg_n;

   localparam int BITS = 3;

   logic            clock = 1'b0;
   logic            reset_n = 1'b0;
   logic [BITS-1:0] DIN = '0;
   logic [2:0]      SEL = '0;
   logic            WE = 1'b0;
   logic            AUTO = 1'b0;
   logic            CLR = 1'b0;
   logic [BITS-1:0] Q0, Q1, Q2, Q3, Q4, Q5, Q6, Q7;
   logic [7:0]      VALID;
   logic [2:0]      PTR;
   logic            FULL;
   logic            DONE;

   demux_1x8_reg_n #(.BITS(BITS)) dut (
      .clock(clock), .reset_n(reset_n), .DIN(DIN), .SEL(SEL), .WE(WE),
      .AUTO(AUTO), .CLR(CLR), .Q0(Q0), .Q1(Q1), .Q2(Q2), .Q3(Q3),
      .Q4(Q4), .Q5(Q5), .Q6(Q6), .Q7(Q7), .VALID(VALID), .PTR(PTR),
      .FULL(FULL), .DONE(DONE)
   );

   always #5 clock = ~clock;

   logic [BITS-1:0] dq [8];
   assign dq[0] = Q0;
   assign dq[1] = Q1;
   assign dq[2] = Q2;
   assign dq[3] = Q3;
   assign dq[4] = Q4;
   assign dq[5] = Q5;
   assign dq[6] = Q6;
   assign dq[7] = Q7;

   // reference model state
   int unsigned m_q [8];
   bit          m_valid [8];
   int unsigned m_ptr;
   bit          m_full;
   bit          m_done;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int unsigned valid_mask();
      int unsigned m = 0;
      for (int i = 0; i < 8; i++) if (m_valid[i]) m += (1 << i);
      return m;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 8; i++) begin
         m_q[i] = 0;
         m_valid[i] = 0;
      end
      m_ptr  = 0;
      m_full = 0;
      m_done = 0;
   endtask

   task automatic check_all(input string tag);
      for (int i = 0; i < 8; i++) chk($sformatf("%s.Q%0d", tag, i), dq[i], m_q[i]);
      chk({tag, ".VALID"}, VALID, valid_mask());
      chk({tag, ".PTR"}, PTR, m_ptr);
      chk({tag, ".FULL"}, FULL, m_full);
      chk({tag, ".DONE"}, DONE, m_done);
   endtask

   // one clock: drive, take the edge, advance the model, compare
   task automatic step(input bit we, input bit au, input int unsigned sel,
                       input int unsigned din, input bit clr, input string tag);
      bit was_full;
      int slot;
      WE = we; AUTO = au; SEL = sel[2:0]; DIN = din[BITS-1:0]; CLR = clr;
      @(posedge clock);
      #1;
      was_full = m_full;
      if (clr) begin
         model_clear();
      end else begin
         slot = -1;
         if (we && !au) slot = int'(sel % 8);
         else if (we && au && !m_full) begin
            slot  = int'(m_ptr);
            m_ptr = (m_ptr + 1) % 8;
         end
         if (slot >= 0) begin
            m_q[slot]     = din % (1 << BITS);
            m_valid[slot] = 1;
         end
         m_full = (valid_mask() == 8'hFF);
      end
      m_done = m_full && !was_full;
      WE = 0; CLR = 0;
      check_all(tag);
   endtask

   initial begin
      model_clear();
      // reset held with WE toggling
      for (int i = 0; i < 3; i++) begin
         WE = i[0]; AUTO = 1; DIN = 3'd7; SEL = 3'd2;
         @(posedge clock); #1;
         check_all("rst_hold");
      end
      WE = 0;
      reset_n = 1;
      step(0, 1, 0, 5, 0, "rst_rel");

      // direct writes
      step(1, 0, 3, 5, 0, "dir1");
      chk("dir1.Q3c", Q3, 5);
      step(1, 0, 3, 2, 0, "dir2");
      chk("dir2.VALIDc", VALID, 8'h08);
      step(0, 0, 0, 0, 1, "clr1");

      // sequential fill and ignored 9th write
      for (int i = 0; i < 8; i++) step(1, 1, 0, i, 0, $sformatf("seq%0d", i));
      chk("seq.FULLc", FULL, 1);
      step(1, 1, 0, 6, 0, "seq9");
      chk("seq9.Q0c", Q0, 0);
      step(0, 0, 0, 0, 1, "clr2");

      // mixed mode
      step(1, 1, 0, 1, 0, "mix1");
      step(1, 1, 0, 2, 0, "mix2");
      step(1, 0, 5, 7, 0, "mix3");
      step(1, 1, 5, 3, 0, "mix4");
      chk("mix.VALIDc", VALID, 8'h27);
      chk("mix.PTRc", PTR, 3);
      step(0, 0, 0, 0, 1, "clr3");

      // direct fill to FULL, then overwrite
      for (int i = 7; i >= 0; i--) step(1, 0, i, i + 1, 0, $sformatf("dfill%0d", i));
      step(1, 0, 0, 4, 0, "dover");
      chk("dover.Q0c", Q0, 4);
      step(0, 0, 0, 0, 1, "clr4");

      // CLR on the eighth sequential write
      for (int i = 0; i < 7; i++) step(1, 1, 0, i, 0, "pre_clr");
      step(1, 1, 0, 7, 1, "clr_win");
      step(0, 1, 0, 0, 0, "clr_win_idle");

      // async reset mid-sequence
      for (int i = 0; i < 4; i++) step(1, 1, 0, i + 2, 0, "pre_rst");
      reset_n = 0;
      #2;
      model_clear();
      check_all("async_rst");
      #3 reset_n = 1;
      step(1, 1, 0, 6, 0, "post_rst");
      chk("post_rst.Q0c", Q0, 6);

      // random traffic
      for (int i = 0; i < 300; i++)
         step(($urandom % 4) != 0, $urandom % 2, $urandom % 8,
              $urandom % (1 << BITS), ($urandom % 24) == 0, "rnd");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
